// File: rtl/reg_access_arb_pkg.sv
// reg_access_pkg: shared state encoding and default sizes for the register-access arbiter
package reg_access_pkg;
  localparam int NREQ_DEF = 2;
  localparam int AW_DEF = 8;
  localparam int DW_DEF = 32;
  localparam int TIMEOUT_DEF = 15;
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
endpackage

// File: rtl/reg_access_arb_if.sv
// reg_access_if: requester handshake plus the shared register-access port
interface reg_access_if import reg_access_pkg::*; #(
  parameter int NREQ = NREQ_DEF,
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
);
  logic [NREQ-1:0] req_valid;
  logic [NREQ-1:0] req_write;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_wdata;
  logic [NREQ-1:0] req_ready;
  logic [NREQ-1:0] rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic rsp_err;
  logic cs;
  logic rd;
  logic wr;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic ack;
  logic [DW-1:0] rdata;
  modport master (
    input req_valid, req_write, req_addr, req_wdata, ack, rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, cs, rd, wr, addr, wdata
  );
  modport slave (
    output req_valid, req_write, req_addr, req_wdata, ack, rdata,
    input req_ready, rsp_valid, rsp_rdata, rsp_err, cs, rd, wr, addr, wdata
  );
endinterface

// File: rtl/reg_access_arb_rr.sv
// rr_arbiter: combinational round-robin pick starting the search at ptr
module rr_arbiter #(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [$clog2(NREQ)-1:0] ptr,
  output logic [NREQ-1:0] grant,
  output logic [$clog2(NREQ)-1:0] idx
);
  localparam int IW = $clog2(NREQ);
  // scanning farthest-first lets the requester nearest to ptr overwrite the others
  always_comb begin
    idx = '0;
    for (int k = NREQ - 1; k >= 0; k--)
      if (req[(int'(ptr) + k) % NREQ]) idx = IW'((int'(ptr) + k) % NREQ);
    grant = |req ? NREQ'(1) << idx : '0;
  end
endmodule

// File: rtl/reg_access_arb.sv
// reg_access_arb: round-robin sequencer sharing one register-access port among NREQ requesters
module reg_access_arb import reg_access_pkg::*; #(
  parameter int NREQ = NREQ_DEF,
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input logic clk,
  input logic rst_n,
  reg_access_if.master bus
);
  localparam int IW = $clog2(NREQ);
  state_t state, state_nxt;
  logic [IW-1:0] ptr, owner, idx;
  logic [NREQ-1:0] grant, rsp_valid_q;
  logic [7:0] cnt;
  logic accept, done, cs_q, rd_q, wr_q, rsp_err_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q, rsp_rdata_q;
  rr_arbiter #(.NREQ(NREQ)) u_rr (.req(bus.req_valid), .ptr(ptr), .grant(grant), .idx(idx));
  assign accept = state == IDLE && |bus.req_valid;
  // ack takes priority when it lands on the final allowed cycle
  assign done = state == ACCESS && (bus.ack || cnt == 8'(TIMEOUT - 1));
  assign bus.req_ready = state == IDLE ? grant : '0;
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  end
  always_comb begin
    state_nxt = state == IDLE ? (accept ? ACCESS : IDLE) :
                state == ACCESS ? (done ? RESP : ACCESS) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr <= '0;
      owner <= '0;
      cnt <= '0;
      cs_q <= 1'b0;
      rd_q <= 1'b0;
      wr_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      rsp_valid_q <= '0;
      if (accept) begin
        owner <= idx;
        ptr <= idx == IW'(NREQ - 1) ? '0 : IW'(idx + 1'b1);
        cnt <= '0;
        cs_q <= 1'b1;
        rd_q <= ~bus.req_write[idx];
        wr_q <= bus.req_write[idx];
        addr_q <= bus.req_addr[idx*AW +: AW];
        wdata_q <= bus.req_wdata[idx*DW +: DW];
      end
      if (state == ACCESS) begin
        cnt <= done ? '0 : cnt + 8'd1;
        if (done) begin
          cs_q <= 1'b0;
          rd_q <= 1'b0;
          wr_q <= 1'b0;
          rsp_valid_q <= NREQ'(1) << owner;
          rsp_rdata_q <= bus.ack && rd_q ? bus.rdata : '0;
          rsp_err_q <= ~bus.ack;
        end
      end
    end
  end
  assign bus.cs = cs_q;
  assign bus.rd = rd_q;
  assign bus.wr = wr_q;
  assign bus.addr = addr_q;
  assign bus.wdata = wdata_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err = rsp_err_q;
endmodule

// File: tb/tb_reg_access_arb.sv
// tb_reg_access_arb: scoreboard bench for reg_access_arb with NREQ=2, TIMEOUT=15
module tb_reg_access_arb;
  typedef struct {
    int who;
    logic [31:0] rdata;
    logic err;
  } exp_t;
  logic clk, rst_n;
  int checks = 0, errors = 0;
  exp_t sb[$];
  reg_access_if #(.NREQ(2), .AW(8), .DW(32)) bus ();
  reg_access_arb #(.NREQ(2), .AW(8), .DW(32), .TIMEOUT(15)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(negedge clk) begin
    exp_t e;
    if (|bus.rsp_valid) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_rsp: rsp_valid=%b but no response was expected", bus.rsp_valid);
      end else begin
        e = sb.pop_front();
        if (bus.rsp_valid !== (2'b01 << e.who) || bus.rsp_rdata !== e.rdata || bus.rsp_err !== e.err) begin
          errors++;
          $display("FAIL rsp: got valid=%b rdata=%h err=%b, expected valid=%b rdata=%h err=%b",
                   bus.rsp_valid, bus.rsp_rdata, bus.rsp_err, 2'b01 << e.who, e.rdata, e.err);
        end
      end
    end
  end
  task automatic clear_inputs();
    bus.req_valid = '0;
    bus.req_write = '0;
    bus.req_addr = '0;
    bus.req_wdata = '0;
    bus.ack = 1'b0;
    bus.rdata = '0;
  endtask
  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask
  task automatic check_idle_outputs(input string name);
    checks++;
    if (bus.cs !== 0 || bus.rd !== 0 || bus.wr !== 0 || bus.addr !== 0 || bus.wdata !== 0 ||
        bus.rsp_valid !== 0 || bus.rsp_rdata !== 0 || bus.rsp_err !== 0) begin
      errors++;
      $display("FAIL %s: cs=%b rd=%b wr=%b addr=%h wdata=%h rsp_valid=%b rsp_rdata=%h rsp_err=%b, expected all 0",
               name, bus.cs, bus.rd, bus.wr, bus.addr, bus.wdata, bus.rsp_valid, bus.rsp_rdata, bus.rsp_err);
    end
  endtask
  // ack_at: ACCESS cycle in which ack is driven (0 = never); sticky holds ack high afterwards
  task automatic do_access(input int who, input bit w, input logic [7:0] a, input logic [31:0] d,
                           input int ack_at, input logic [31:0] rv, input bit sticky, input string name);
    int n = 0;
    int exp_n;
    bit to = (ack_at == 0);
    logic [1:0] oh = 2'b01 << who;
    exp_t e;
    e.who = who;
    e.rdata = (to || w) ? 32'h0 : rv;
    e.err = to;
    exp_n = to ? 15 : ack_at;
    bus.req_valid = oh;
    bus.req_write[who] = w;
    bus.req_addr[who*8 +: 8] = a;
    bus.req_wdata[who*32 +: 32] = d;
    bus.rdata = rv;
    #1;
    checks++;
    if (bus.req_ready !== oh) begin
      errors++;
      $display("FAIL %s_accept: req_ready=%b, expected %b", name, bus.req_ready, oh);
    end
    sb.push_back(e);
    @(negedge clk);
    bus.req_valid = '0;
    for (int c = 1; c <= 40; c++) begin
      if (!bus.cs) break;
      n++;
      checks++;
      if (bus.rd !== !w || bus.wr !== w || bus.addr !== a || bus.wdata !== d || bus.req_ready !== 0) begin
        errors++;
        $display("FAIL %s_strobes: rd=%b wr=%b addr=%h wdata=%h ready=%b, expected rd=%b wr=%b addr=%h wdata=%h ready=00",
                 name, bus.rd, bus.wr, bus.addr, bus.wdata, bus.req_ready, !w, w, a, d);
      end
      bus.ack = (c == ack_at) || (sticky && !to && c > ack_at);
      @(negedge clk);
    end
    checks++;
    if (n != exp_n) begin
      errors++;
      $display("FAIL %s_cs_len: cs high %0d cycles, expected %0d", name, n, exp_n);
    end
    if (!sticky) bus.ack = 1'b0;
  endtask
  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_idle_outputs("reset_outputs");
    checks++;
    if (bus.req_ready !== 2'b00) begin
      errors++;
      $display("FAIL reset_ready: req_ready=%b, expected 00", bus.req_ready);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask
  task automatic test_contention();
    int rises[$];
    int exp_w = 0, owner = 0, grants = 0, low_run = 0;
    bit prev_cs = 0;
    logic [1:0] g;
    exp_t e;
    do_reset();
    bus.req_valid = 2'b11;
    for (int c = 0; c < 18; c++) begin
      #1;
      if (|bus.req_ready) begin
        g = 2'b01 << exp_w;
        checks++;
        if (bus.req_ready !== g) begin
          errors++;
          $display("FAIL contention_grant%0d: req_ready=%b, expected %b", grants, bus.req_ready, g);
        end
        e.who = exp_w;
        e.rdata = 32'hC0DE_0000 + 32'(exp_w);
        e.err = 1'b0;
        sb.push_back(e);
        owner = exp_w;
        exp_w ^= 1;
        grants++;
      end
      if (bus.cs && !prev_cs) begin
        rises.push_back(c);
        if (rises.size() > 1) begin
          checks++;
          if (low_run != 2) begin
            errors++;
            $display("FAIL contention_gap: cs low %0d cycles, expected 2", low_run);
          end
        end
      end
      low_run = bus.cs ? 0 : low_run + 1;
      prev_cs = bus.cs;
      bus.ack = bus.cs;
      bus.rdata = 32'hC0DE_0000 + 32'(owner);
      @(negedge clk);
    end
    clear_inputs();
    checks++;
    if (grants != 6 || rises.size() != 6) begin
      errors++;
      $display("FAIL contention_count: grants=%0d cs_rises=%0d, expected 6 and 6", grants, rises.size());
    end
    for (int i = 1; i < rises.size(); i++) begin
      checks++;
      if (rises[i] - rises[i-1] != 3) begin
        errors++;
        $display("FAIL contention_period: cs rise spacing %0d, expected 3", rises[i] - rises[i-1]);
      end
    end
    @(negedge clk);
  endtask
  task automatic test_single_read();
    do_reset();
    do_access(0, 1'b0, 8'h10, 32'h0, 3, 32'hDEADBEEF, 1'b0, "single_read");
    @(negedge clk);
  endtask
  task automatic test_write_ack();
    do_access(1, 1'b1, 8'hA5, 32'h1234_5678, 1, 32'hFFFF_FFFF, 1'b0, "write_ack");
    @(negedge clk);
  endtask
  task automatic test_timeout();
    do_access(0, 1'b1, 8'h20, 32'h55, 0, 32'hBAD0_BAD0, 1'b0, "timeout");
    @(negedge clk);
  endtask
  task automatic test_ack_boundary();
    do_access(1, 1'b0, 8'h30, 32'h0, 15, 32'hFEED_F00D, 1'b0, "ack_boundary");
    @(negedge clk);
  endtask
  task automatic test_stray_ack();
    bus.ack = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (bus.cs !== 0 || bus.req_ready !== 0) begin
        errors++;
        $display("FAIL stray_idle: cs=%b ready=%b, expected 0 and 00", bus.cs, bus.req_ready);
      end
    end
    bus.ack = 1'b0;
    do_access(1, 1'b0, 8'h33, 32'h0, 1, 32'h0000_1234, 1'b1, "stray_resp");
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (bus.cs !== 0) begin
        errors++;
        $display("FAIL stray_after: cs=%b, expected 0", bus.cs);
      end
    end
    bus.ack = 1'b0;
    @(negedge clk);
  endtask
  task automatic test_reset_mid();
    do_reset();
    bus.req_valid = 2'b01;
    bus.req_addr[7:0] = 8'h44;
    bus.req_wdata[31:0] = 32'hAAAA_5555;
    #1;
    checks++;
    if (bus.req_ready !== 2'b01) begin
      errors++;
      $display("FAIL reset_mid_accept: req_ready=%b, expected 01", bus.req_ready);
    end
    @(negedge clk);
    bus.req_valid = '0;
    @(negedge clk);
    checks++;
    if (bus.cs !== 1) begin
      errors++;
      $display("FAIL reset_mid_cs: cs=%b before reset, expected 1", bus.cs);
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_idle_outputs("reset_mid_outputs");
    repeat (3) @(negedge clk);
    check_idle_outputs("reset_mid_quiet");
    bus.req_valid = 2'b11;
    #1;
    checks++;
    if (bus.req_ready !== 2'b01) begin
      errors++;
      $display("FAIL reset_mid_ptr: req_ready=%b, expected 01", bus.req_ready);
    end
    bus.req_valid = '0;
    @(negedge clk);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
  initial begin
    test_reset();
    test_contention();
    test_single_read();
    test_write_ack();
    test_timeout();
    test_ack_boundary();
    test_stray_ack();
    test_reset_mid();
    repeat (2) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d responses never arrived, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
